// File: rtl/regbank_wb_arbiter.sv
// Round-robin writeback arbiter for the regbank write port, with a registered
// write stage and a pending-write scoreboard over the scalar and predicate files.
module regbank_wb_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned REG_SEL      = 5,
  parameter int unsigned PRED_REG_SEL = 3,
  parameter logic        S_REGS       = 1'b0,
  parameter logic        P_REGS       = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_sel,
  input  logic [NUM_REQ*REG_SEL-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic                       write_enable,
  output logic                       z_regbank_sel,
  output logic [REG_SEL-1:0]         z_regbank_addr,
  output logic [WIDTH-1:0]           z_data,
  input  logic                       issue_valid,
  input  logic                       issue_sel,
  input  logic [REG_SEL-1:0]         issue_addr,
  output logic                       issue_ready,
  input  logic                       a_regbank_sel,
  input  logic [REG_SEL-1:0]         a_regbank_addr,
  input  logic                       b_regbank_sel,
  input  logic [REG_SEL-1:0]         b_regbank_addr,
  output logic                       a_pending,
  output logic                       b_pending
);

  localparam int unsigned PW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NUM_REGS      = 2 ** REG_SEL;
  localparam int unsigned NUM_PRED_REGS = 2 ** PRED_REG_SEL;
  localparam logic [REG_SEL-1:0] PMASK  = REG_SEL'((64'd1 << PRED_REG_SEL) - 64'd1);

  logic [PW-1:0]            ptr_q, ptr_d;
  logic                     we_q, we_d;
  logic                     zsel_q, zsel_d;
  logic [REG_SEL-1:0]       zaddr_q, zaddr_d;
  logic [WIDTH-1:0]         zdata_q, zdata_d;
  logic [NUM_REGS-1:0]      busy_s_q, busy_s_d;
  logic [NUM_PRED_REGS-1:0] busy_p_q, busy_p_d;

  logic [NUM_REQ-1:0]       grant;
  logic                     found;
  logic [PW-1:0]            gnt_idx;
  logic                     set_en;

  function automatic logic [REG_SEL-1:0] mask_addr(input logic sel,
                                                   input logic [REG_SEL-1:0] addr);
    return (sel == P_REGS) ? (addr & PMASK) : addr;
  endfunction

  function automatic logic busy_at(input logic sel, input logic [REG_SEL-1:0] addr);
    return (sel == P_REGS) ? busy_p_q[addr[PRED_REG_SEL-1:0]] : busy_s_q[addr];
  endfunction

  // Search from ptr upward with wrap; first valid requester wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    if (!reset_n) found = 1'b0;
    if (found) grant[gnt_idx] = 1'b1;
  end

  assign req_ready = grant;

  always_comb begin
    ptr_d   = ptr_q;
    we_d    = found;
    zsel_d  = zsel_q;
    zaddr_d = zaddr_q;
    zdata_d = zdata_q;
    if (found) begin
      ptr_d   = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      zsel_d  = req_sel[gnt_idx];
      zaddr_d = mask_addr(req_sel[gnt_idx], req_addr[32'(gnt_idx)*REG_SEL +: REG_SEL]);
      zdata_d = req_data[32'(gnt_idx)*WIDTH +: WIDTH];
    end
  end

  assign issue_ready = !busy_at(issue_sel, issue_addr);
  assign set_en      = issue_valid && issue_ready;
  assign a_pending   = busy_at(a_regbank_sel, a_regbank_addr);
  assign b_pending   = busy_at(b_regbank_sel, b_regbank_addr);

  // Clear first, then set, so a same-cycle set on the cleared bit wins.
  always_comb begin
    busy_s_d = busy_s_q;
    busy_p_d = busy_p_q;
    if (we_q) begin
      if (zsel_q == P_REGS) busy_p_d[zaddr_q[PRED_REG_SEL-1:0]] = 1'b0;
      else                  busy_s_d[zaddr_q] = 1'b0;
    end
    if (set_en) begin
      if (issue_sel == P_REGS) busy_p_d[issue_addr[PRED_REG_SEL-1:0]] = 1'b1;
      else                     busy_s_d[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q    <= '0;
      we_q     <= 1'b0;
      zsel_q   <= 1'b0;
      zaddr_q  <= '0;
      zdata_q  <= '0;
      busy_s_q <= '0;
      busy_p_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      we_q     <= we_d;
      zsel_q   <= zsel_d;
      zaddr_q  <= zaddr_d;
      zdata_q  <= zdata_d;
      busy_s_q <= busy_s_d;
      busy_p_q <= busy_p_d;
    end
  end

  assign write_enable   = we_q;
  assign z_regbank_sel  = zsel_q;
  assign z_regbank_addr = zaddr_q;
  assign z_data         = zdata_q;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter: vector table for arbitration plus
// hand sequences for scoreboard, masking and reset corner cases.
module tb_regbank_wb_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned W  = 32;
  localparam int unsigned RS = 5;
  localparam int unsigned PS = 3;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [NR-1:0]  req_valid, req_ready, req_sel;
  logic [NR*RS-1:0] req_addr;
  logic [NR*W-1:0]  req_data;
  logic           write_enable, z_regbank_sel;
  logic [RS-1:0]  z_regbank_addr;
  logic [W-1:0]   z_data;
  logic           issue_valid, issue_sel, issue_ready;
  logic [RS-1:0]  issue_addr;
  logic           a_regbank_sel, b_regbank_sel, a_pending, b_pending;
  logic [RS-1:0]  a_regbank_addr, b_regbank_addr;

  int checks = 0;
  int errors = 0;

  regbank_wb_arbiter #(
    .NUM_REQ(NR), .WIDTH(W), .REG_SEL(RS), .PRED_REG_SEL(PS),
    .S_REGS(1'b0), .P_REGS(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_addr(req_addr), .req_data(req_data),
    .write_enable(write_enable), .z_regbank_sel(z_regbank_sel),
    .z_regbank_addr(z_regbank_addr), .z_data(z_data),
    .issue_valid(issue_valid), .issue_sel(issue_sel), .issue_addr(issue_addr),
    .issue_ready(issue_ready),
    .a_regbank_sel(a_regbank_sel), .a_regbank_addr(a_regbank_addr),
    .b_regbank_sel(b_regbank_sel), .b_regbank_addr(b_regbank_addr),
    .a_pending(a_pending), .b_pending(b_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] ready;
    logic          we;
    logic [RS-1:0] addr;
    logic [W-1:0]  data;
  } vec_t;

  vec_t tv[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    issue_valid = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0]  = '{3'b111, 3'b001, 1'b1, 5'd1, 32'h100};
    tv[1]  = '{3'b111, 3'b010, 1'b1, 5'd2, 32'h101};
    tv[2]  = '{3'b111, 3'b100, 1'b1, 5'd3, 32'h102};
    tv[3]  = '{3'b111, 3'b001, 1'b1, 5'd1, 32'h100};
    tv[4]  = '{3'b111, 3'b010, 1'b1, 5'd2, 32'h101};
    tv[5]  = '{3'b111, 3'b100, 1'b1, 5'd3, 32'h102};
    tv[6]  = '{3'b101, 3'b001, 1'b1, 5'd1, 32'h100};
    tv[7]  = '{3'b101, 3'b100, 1'b1, 5'd3, 32'h102};
    tv[8]  = '{3'b000, 3'b000, 1'b0, 5'd3, 32'h102};
    tv[9]  = '{3'b010, 3'b010, 1'b1, 5'd2, 32'h101};
    tv[10] = '{3'b001, 3'b001, 1'b1, 5'd1, 32'h100};

    reset_n = 1'b0; req_valid = '0; req_sel = '0; req_addr = '0; req_data = '0;
    issue_valid = 1'b0; issue_sel = 1'b0; issue_addr = '0;
    a_regbank_sel = 1'b0; a_regbank_addr = '0;
    b_regbank_sel = 1'b0; b_regbank_addr = '0;
    step();
    do_reset();

    // Reset state
    chk("rst_we", write_enable, 0);
    chk("rst_zaddr", z_regbank_addr, 0);
    chk("rst_zdata", z_data, 0);
    chk("rst_issue_ready", issue_ready, 1);

    // Single write from requester 1
    req_valid = 3'b010;
    req_addr[1*RS +: RS] = 5'd5;
    req_data[1*W +: W] = 32'hDEAD;
    #1 chk("single_ready", req_ready, 3'b010);
    step();
    req_valid = '0;
    chk("single_we", write_enable, 1);
    chk("single_zaddr", z_regbank_addr, 5);
    chk("single_zdata", z_data, 32'hDEAD);
    chk("single_zsel", z_regbank_sel, 0);
    step();
    chk("single_we_off", write_enable, 0);

    // Round-robin table
    do_reset();
    for (int i = 0; i < NR; i++) begin
      req_addr[i*RS +: RS] = RS'(i + 1);
      req_data[i*W +: W]   = 32'h100 + 32'(i);
    end
    for (int i = 0; i < 11; i++) begin
      req_valid = tv[i].valid;
      #1 chk($sformatf("rr%0d_ready", i), req_ready, tv[i].ready);
      step();
      chk($sformatf("rr%0d_we", i), write_enable, tv[i].we);
      chk($sformatf("rr%0d_zaddr", i), z_regbank_addr, tv[i].addr);
      chk($sformatf("rr%0d_zdata", i), z_data, tv[i].data);
    end
    req_valid = '0;

    // Scoreboard RAW on S r3
    issue_valid = 1'b1; issue_sel = 1'b0; issue_addr = 5'd3;
    #1 chk("raw_issue_ready", issue_ready, 1);
    step();
    issue_valid = 1'b0;
    a_regbank_sel = 1'b0; a_regbank_addr = 5'd3;
    b_regbank_sel = 1'b0; b_regbank_addr = 5'd4;
    #1 chk("raw_a_pend", a_pending, 1);
    chk("raw_b_clear", b_pending, 0);
    issue_valid = 1'b1;
    #1 chk("raw_waw_block", issue_ready, 0);
    issue_valid = 1'b0;
    req_addr[0 +: RS] = 5'd3;
    req_valid = 3'b001;
    #1 chk("raw_hs_ready", req_ready, 3'b001);
    chk("raw_pend_N", a_pending, 1);
    step();
    req_valid = '0;
    chk("raw_we_N1", write_enable, 1);
    chk("raw_pend_N1", a_pending, 1);
    step();
    chk("raw_pend_N2", a_pending, 0);
    chk("raw_ready_N2", issue_ready, 1);

    // Set/clear collision: write to idle r3 while re-issuing r3
    req_valid = 3'b001;
    step();
    req_valid = '0;
    chk("col_we", write_enable, 1);
    issue_valid = 1'b1; issue_addr = 5'd3;
    #1 chk("col_issue_ready", issue_ready, 1);
    step();
    issue_valid = 1'b0;
    chk("col_busy_kept", issue_ready, 0);
    chk("col_a_pend", a_pending, 1);
    req_valid = 3'b001;
    step();
    req_valid = '0;
    step();
    chk("col_cleared", a_pending, 0);

    // Predicate masking
    issue_valid = 1'b1; issue_sel = 1'b1; issue_addr = 5'h1F;
    #1 chk("pred_issue_ready", issue_ready, 1);
    step();
    issue_valid = 1'b0;
    a_regbank_sel = 1'b1; a_regbank_addr = 5'h07;
    b_regbank_sel = 1'b0; b_regbank_addr = 5'h1F;
    #1 chk("pred_a_pend", a_pending, 1);
    chk("pred_s31_idle", b_pending, 0);
    req_sel[0] = 1'b1;
    req_addr[0 +: RS] = 5'h1F;
    req_valid = 3'b001;
    step();
    req_valid = '0;
    chk("pred_we", write_enable, 1);
    chk("pred_zsel", z_regbank_sel, 1);
    chk("pred_zaddr_lo", z_regbank_addr[PS-1:0], 3'b111);
    step();
    chk("pred_cleared", a_pending, 0);
    req_sel = '0;

    // Reset mid-operation
    issue_valid = 1'b1; issue_sel = 1'b0; issue_addr = 5'd10;
    step();
    issue_addr = 5'd11;
    step();
    issue_valid = 1'b0;
    a_regbank_sel = 1'b0; a_regbank_addr = 5'd10;
    b_regbank_sel = 1'b0; b_regbank_addr = 5'd11;
    #1 chk("mid_a_busy", a_pending, 1);
    chk("mid_b_busy", b_pending, 1);
    req_valid = 3'b100;
    step();
    req_valid = '0;
    chk("mid_we", write_enable, 1);
    reset_n = 1'b0;
    req_valid = 3'b111;
    #1 chk("mid_ready_in_reset", req_ready, 0);
    step();
    reset_n = 1'b1;
    req_valid = '0;
    chk("mid_we_off", write_enable, 0);
    chk("mid_zsel", z_regbank_sel, 0);
    chk("mid_zaddr", z_regbank_addr, 0);
    chk("mid_zdata", z_data, 0);
    #1 chk("mid_a_clear", a_pending, 0);
    chk("mid_b_clear", b_pending, 0);
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < (s == 0 ? 32 : 8); r++) begin
        issue_sel = s[0];
        issue_addr = RS'(r);
        #1 chk($sformatf("mid_ready_s%0d_r%0d", s, r), issue_ready, 1);
      end
    end
    req_valid = 3'b111;
    #1 chk("mid_ptr0", req_ready, 3'b001);
    req_valid = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_wb_arbiter.md
# regbank_wb_arbiter

Shares the regbank's single write port between `NUM_REQ` writeback requesters using a round-robin arbiter with a registered write stage. It also keeps a pending-write scoreboard over the scalar (`S_REGS`) and predicate (`P_REGS`) files. Issue logic uses the scoreboard to stall on RAW and WAW hazards. It sits between the execution units and regbank, and drives `write_enable`, `z_regbank_sel`, `z_regbank_addr` and `z_data` directly.

## Interface
- `NUM_REQ`, default 3: number of writeback requesters, range 2..8.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `req_valid` in NUM_REQ: requester i has a write pending.
- `req_ready` out NUM_REQ: one-hot grant; requester i's write is accepted this cycle.
- `req_sel` in NUM_REQ: regbank select per requester (`S_REGS`/`P_REGS`).
- `req_addr` in NUM_REQ*`REG_SEL`: packed destination address; slice i is `[i*REG_SEL +: REG_SEL]`.
- `req_data` in NUM_REQ*`WIDTH`: packed write data.
- `write_enable` out 1: registered write strobe to regbank.
- `z_regbank_sel` out 1: registered select to regbank.
- `z_regbank_addr` out `REG_SEL`: registered address to regbank.
- `z_data` out `WIDTH`: registered data to regbank.
- `issue_valid` in 1: issue stage wants to reserve a destination.
- `issue_sel` in 1: select for the reserved destination.
- `issue_addr` in `REG_SEL`: address of the reserved destination.
- `issue_ready` out 1: reservation accepted (no WAW conflict).
- `a_regbank_sel` in 1 / `a_regbank_addr` in `REG_SEL`: source A being checked.
- `b_regbank_sel` in 1 / `b_regbank_addr` in `REG_SEL`: source B being checked.
- `a_pending` out 1: combinational; source A has a write outstanding.
- `b_pending` out 1: combinational; source B has a write outstanding.

## Operation
- **Arbitration**
  - The round-robin pointer `ptr` has range 0..NUM_REQ-1.
  - The grant goes to the first i with `req_valid[i]`, searching from `ptr` upward with wrap.
  - `req_ready` is combinational from `req_valid` and `ptr`. It is at most one-hot and is zero when no request is valid.
  - A request with `req_valid` low is never granted.
  - On a grant to g, `ptr` becomes (g+1) mod NUM_REQ. With no grant, `ptr` holds.
- **Write stage**
  - Every cycle, `write_enable` is registered as "any grant".
  - On a grant, `z_*` are registered from the granted slice.
  - With no grant, `z_*` hold their previous values and `write_enable` is 0.
- **Address masking**
  - `P_REGS` addresses use only the low `PRED_REG_SEL` bits.
  - `S_REGS` addresses use the full `REG_SEL` bits.
  - The scoreboard and the `z_regbank_addr` output apply the same masking.
- **Scoreboard**
  - Busy bits: `busy_s[NUM_REGS]` and `busy_p[NUM_PRED_REGS]`.
  - `issue_ready` is `!busy[issue_sel][issue_addr]`.
  - When `issue_valid && issue_ready`, the bit is set at the edge.
  - When the registered `write_enable` is 1, the bit at `z_regbank_sel`/`z_regbank_addr` is cleared at the same edge on which regbank commits the write.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - A write to a non-busy register is legal; the clear has no effect.
- **Pending outputs**
  - `a_pending` = busy bit at (`a_regbank_sel`, `a_regbank_addr`).
  - `b_pending` = busy bit at (`b_regbank_sel`, `b_regbank_addr`).
  - Both are pure lookups with no write-stage bypass. When a pending flag falls, regbank already holds the new data.
- **Reset** (`reset_n` low at an edge)
  - `ptr` = 0, `write_enable` = 0, `z_regbank_sel` = 0, `z_regbank_addr` = 0, `z_data` = 0, all busy bits = 0.
  - Reset overrides any grant, set or clear in that cycle.
  - A write held in the output register is discarded.
  - `req_ready` is forced to 0 while `reset_n` is low.
  - `issue_ready` reads 1 after the reset edge.

## Timing
- Grant to regbank write: the handshake in cycle N drives `write_enable` in N+1, and the regbank array updates at the end of N+1.
- Busy bit to pending: a busy bit clears at the end of N+1, and `a_pending`/`b_pending` for that register fall in N+2.
- Issue to pending: an issue in cycle N shows `a_pending` high from N+1.
- Throughput: one write per cycle sustained.
- Fairness: under continuous contention from all requesters, each requester waits at most NUM_REQ-1 cycles.
- The only combinational paths are `req_valid` → `req_ready`, issue address → `issue_ready`, and source address → `*_pending`.

## Test plan
- **Single write.** Reset, then `req_valid[1]`=1 with `S_REGS`, addr 5, data 0xDEAD for one cycle.
  - `req_ready`=3'b010 that cycle.
  - Next cycle: `write_enable`=1, `z_regbank_addr`=5, `z_data`=0xDEAD.
  - Cycle after: `write_enable`=0.
- **Round-robin.** Hold all three `req_valid` high for 6 cycles from `ptr`=0.
  - Grants run 0,1,2,0,1,2.
  - Dropping `req_valid[1]` mid-run skips requester 1 without stalling.
- **Scoreboard RAW.** Issue `S_REGS` r3.
  - Next cycle: `a_pending`=1 for r3.
  - After the writeback handshake at N: `a_pending`=1 through N+1, 0 at N+2.
  - A second issue to r3 before the clear sees `issue_ready`=0.
- **Set/clear collision.** Re-issue r3 in the cycle `write_enable` clears r3.
  - The busy bit stays 1 and `issue_ready` for r3 is 0 the following cycle.
- **Predicate masking.** `P_REGS` write with `req_addr` = all ones.
  - `z_regbank_addr` low `PRED_REG_SEL` bits are all ones.
  - The busy bit cleared is `busy_p[NUM_PRED_REGS-1]`.
- **Reset mid-operation.** Assert `reset_n`=0 in the cycle `write_enable`=1 with two busy bits set.
  - Next cycle: `write_enable`=0, `z_*`=0, `issue_ready`=1 for all addresses, `ptr`=0.
